cic3_row_readout: RTL and testbench
===================================

// Module: cic3_row_readout
// PURPOSE
//  Consumes the packed outputs of the 2x12 CIC3 filter row (24 ch x 25 b) at the decimated rate.
//  On each sample strobe, snapshots all channels into shadow regs, then streams them out one
//  word per handshake (ch 0..NUM_CHANNELS-1) over valid/ready to the chip readout/FIFO.
//  Flags frames lost while a previous frame is still draining.
// PARAMETERS
//  NUM_CHANNELS  24  filters in the row (2 subsections x 12)
//  DATA_WIDTH    25  bits per filter output
//  CH_ID_WIDTH   5   channel index width, >= clog2(NUM_CHANNELS)
//  FRAME_W       16  frame counter width
// PORTS
//  clk          in   1                          common modulator/system clock
//  reset        in   1                          synchronous, active-high reset
//  filt_data    in   NUM_CHANNELS*DATA_WIDTH    packed row output; ch k = [k*DW +: DW]
//  sample_valid in   1                          1-cycle pulse: filt_data valid this cycle
//  enable       in   1                          accept new frames when 1
//  out_data     out  DATA_WIDTH                 current channel word
//  out_chan     out  CH_ID_WIDTH                channel index of out_data
//  out_last     out  1                          high with last channel of frame
//  out_valid    out  1                          word valid
//  out_ready    in   1                          consumer accepts word
//  busy         out  1                          frame in shadow regs not fully sent
//  overrun      out  1                          sticky: a frame was dropped
//  overrun_clr  in   1                          clears overrun
//  frame_cnt    out  FRAME_W                    completed frames, wraps
// BEHAVIOUR
//  Reset (sync, clk edge with reset=1): all outputs 0, shadow regs 0, FSM IDLE. Overrides all.
//  Reset mid-frame: frame abandoned, no out_last, frame_cnt unchanged.
//  FSM IDLE: out_valid=0, busy=0. sample_valid&&enable -> shadow<=filt_data, idx<=0, go SEND.
//    sample_valid&&!enable: ignored, no overrun.
//  FSM SEND: out_valid=1, busy=1, out_data=shadow[idx], out_chan=idx, out_last=(idx==NUM_CHANNELS-1).
//    Handshake = out_valid&&out_ready. On handshake idx<=idx+1; on handshake with out_last:
//    frame_cnt<=frame_cnt+1 (wraps 2^FRAME_W-1 -> 0), go IDLE.
//    out_data/out_chan/out_last stable while out_valid&&!out_ready (no change on stall).
//  Latency: first word (ch 0) valid the cycle after the accepted sample_valid.
//    Zero-stall frame: NUM_CHANNELS consecutive cycles of out_valid.
//  sample_valid in SEND: frame dropped, shadow untouched, overrun<=1.
//    Exception: same cycle as out_last handshake -> accepted as new frame (snapshot, idx<=0,
//    stay SEND; no gap, next word is ch 0 of new frame), needs enable=1, no overrun.
//  enable dropped mid-frame: current frame completes; only new frames gated.
//  overrun: set on dropped frame; cleared by overrun_clr; set and clr same cycle -> set wins.
//  Shadow capture is the only read of filt_data; filt_data may change freely afterwards.
//  All outputs registered; no combinational path out_ready -> out_valid.
// TESTING
//  T1 reset: reset=1 3 cycles with random inputs -> all outputs 0; after release out_valid=0.
//  T2 basic: filt_data ch k = k*1000+7, sample_valid 1 cycle, out_ready=1 -> next 24 cycles
//     out_chan 0..23, out_data k*1000+7, out_last only at ch 23, frame_cnt 0->1, busy then 0.
//  T3 backpressure: out_ready random 30% duty, filt_data changed after strobe -> same 24 words
//     from snapshot, no word skipped/duplicated, out_data stable during stalls.
//  T4 overrun: second strobe at ch 5 of frame -> frame ignored, overrun=1 held;
//     overrun_clr pulse -> 0; clr with new drop same cycle -> stays 1.
//  T5 back-to-back: strobe coincident with ch 23 handshake -> next cycle ch 0 of new data,
//     overrun=0, frame_cnt +2 total after both frames.
//  T6 wrap/enable: preload frame_cnt to 16'hFFFF via 65535 frames (or force) -> next frame gives 0;
//     enable=0 strobe in IDLE -> no output, no overrun; reset at ch 10 -> idle, frame_cnt held.

Source files
------------

// File: rtl/cic3_row_readout.sv
// Snapshots one decimated CIC3 row (all channels) into shadow registers and streams it out
// channel by channel over a valid/ready interface, flagging frames that arrive while busy.
module cic3_row_readout #(
  parameter int NUM_CHANNELS = 24,
  parameter int DATA_WIDTH   = 25,
  parameter int CH_ID_WIDTH  = 5,
  parameter int FRAME_W      = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] filt_data,
  input  logic                               sample_valid,
  input  logic                               enable,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [CH_ID_WIDTH-1:0]             out_chan,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               overrun,
  input  logic                               overrun_clr,
  output logic [FRAME_W-1:0]                 frame_cnt
);

  localparam logic [CH_ID_WIDTH-1:0] LAST_CH = CH_ID_WIDTH'(NUM_CHANNELS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shadow [NUM_CHANNELS];
  logic                    hs;
  logic                    last_hs;
  logic                    accept;
  logic                    drop;
  logic [CH_ID_WIDTH-1:0]  next_chan;

  // A strobe landing on the final handshake starts the next frame without a gap.
  assign hs        = out_valid && out_ready;
  assign last_hs   = hs && out_last;
  assign accept    = sample_valid && enable && ((state == IDLE) || last_hs);
  assign drop      = sample_valid && (state == SEND) && !last_hs;
  assign next_chan = out_chan + CH_ID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      if (accept) begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          shadow[k] <= filt_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        // Channel 0 comes straight from the input since shadow is being written this cycle.
        out_data  <= filt_data[DATA_WIDTH-1:0];
        out_chan  <= '0;
        out_last  <= (LAST_CH == '0);
        out_valid <= 1'b1;
        busy      <= 1'b1;
        state     <= SEND;
      end else if (hs) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end else begin
          out_chan <= next_chan;
          out_data <= shadow[next_chan];
          out_last <= (next_chan == LAST_CH);
        end
      end

      if (last_hs) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic3_row_readout.sv
// Directed bench for cic3_row_readout: a queue-based frame model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_cic3_row_readout;

  localparam int NC = 24;
  localparam int DW = 25;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC*DW-1:0] filt_data;
  logic             sample_valid;
  logic             enable;
  logic             out_ready;
  logic             overrun_clr;

  logic [DW-1:0]    out_data;
  logic [4:0]       out_chan;
  logic             out_last, out_valid, busy, overrun;
  logic [15:0]      frame_cnt;

  logic [DW-1:0]    out_data_w;
  logic [4:0]       out_chan_w;
  logic             out_last_w, out_valid_w, busy_w, overrun_w;
  logic [3:0]       frame_cnt_w;

  always #5 clk = ~clk;

  cic3_row_readout dut (
    .clk(clk), .reset(reset), .filt_data(filt_data), .sample_valid(sample_valid),
    .enable(enable), .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun),
    .overrun_clr(overrun_clr), .frame_cnt(frame_cnt)
  );

  // Narrow frame counter instance sharing all inputs, used to observe counter wrap.
  cic3_row_readout #(.FRAME_W(4)) dut_w (
    .clk(clk), .reset(reset), .filt_data(filt_data), .sample_valid(sample_valid),
    .enable(enable), .out_data(out_data_w), .out_chan(out_chan_w), .out_last(out_last_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .busy(busy_w), .overrun(overrun_w),
    .overrun_clr(overrun_clr), .frame_cnt(frame_cnt_w)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [4:0]    c;
    logic          l;
  } word_t;

  word_t exp_q[$];
  logic  m_ovr = 1'b0;
  int    m_cnt = 0;
  bit    armed = 0;
  bit    rst_prev = 0;

  // Model: a frame is a list of words; output is the head of the list; handshakes pop it.
  always @(negedge clk) begin
    bit    was_busy, last_hs, set_ovr;
    word_t w;
    if (armed) begin
      chk("out_valid", out_valid, 32'(exp_q.size() != 0));
      chk("busy", busy, 32'(exp_q.size() != 0));
      chk("overrun", overrun, 32'(m_ovr));
      chk("frame_cnt", frame_cnt, 32'(m_cnt[15:0]));
      chk("frame_cnt_w", frame_cnt_w, 32'(m_cnt[3:0]));
      chk("out_valid_w", out_valid_w, 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_data", out_data, 32'(exp_q[0].d));
        chk("out_chan", out_chan, 32'(exp_q[0].c));
        chk("out_last", out_last, 32'(exp_q[0].l));
      end
      if (rst_prev) begin
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_chan", out_chan, 32'd0);
        chk("rst_out_last", out_last, 32'd0);
      end
    end
    armed    = 1;
    rst_prev = reset;
    if (reset) begin
      exp_q.delete();
      m_ovr = 1'b0;
      m_cnt = 0;
    end else begin
      was_busy = (exp_q.size() != 0);
      last_hs  = 0;
      set_ovr  = 0;
      if (was_busy && out_ready) begin
        last_hs = exp_q[0].l;
        void'(exp_q.pop_front());
      end
      if (last_hs) m_cnt++;
      if (sample_valid) begin
        if (!was_busy || last_hs) begin
          if (enable) begin
            for (int k = 0; k < NC; k++) begin
              w.d = filt_data[k*DW +: DW];
              w.c = 5'(k);
              w.l = (k == NC - 1);
              exp_q.push_back(w);
            end
          end
        end else begin
          set_ovr = 1;
        end
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pat(input int base, input int mul);
    for (int k = 0; k < NC; k++) filt_data[k*DW +: DW] = DW'(base + k * mul);
  endtask

  task automatic strobe();
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; filt_data = '0; sample_valid = 1'b0; enable = 1'b1;
    out_ready = 1'b1; overrun_clr = 1'b0;

    // T1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NC; k++) filt_data[k*DW +: DW] = DW'($urandom);
      sample_valid = 1'($urandom); out_ready = 1'($urandom); overrun_clr = 1'($urandom);
      step();
    end
    chk("t1_valid_in_reset", out_valid, 32'd0);
    chk("t1_cnt_in_reset", frame_cnt, 32'd0);
    reset = 1'b0; sample_valid = 1'b0; out_ready = 1'b1; overrun_clr = 1'b0;
    step(); step();
    chk("t1_valid_after", out_valid, 32'd0);

    // T6a: reset in the middle of a frame
    set_pat(100, 1);
    strobe();
    repeat (10) step();
    chk("t6_chan10", out_chan, 32'd10);
    chk("t6_data10", out_data, 32'd110);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_rst_valid", out_valid, 32'd0);
    chk("t6_rst_cnt", frame_cnt, 32'd0);
    step();

    // T2: basic frame, no stalls
    set_pat(7, 1000);
    strobe();
    chk("t2_ch0_data", out_data, 32'd7);
    chk("t2_ch0_valid", out_valid, 32'd1);
    repeat (23) step();
    chk("t2_ch23_data", out_data, 32'd23007);
    chk("t2_ch23_last", out_last, 32'd1);
    step();
    chk("t2_cnt", frame_cnt, 32'd1);
    chk("t2_busy", busy, 32'd0);

    // T3: random backpressure, input changed and enable dropped mid-frame
    set_pat(32'h1000000, 3);
    out_ready = ($urandom_range(0, 9) < 3);
    strobe();
    filt_data = '1;
    enable = 1'b0;
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
      out_ready = ($urandom_range(0, 9) < 3);
      step();
    end
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1; enable = 1'b1;
    step();
    chk("t3_cnt", frame_cnt, 32'd2);

    // T4: overrun set, clear, and set-wins-over-clear
    set_pat(500, 2);
    strobe();
    repeat (5) step();
    chk("t4_chan5", out_chan, 32'd5);
    set_pat(9000, 1);
    strobe();
    wait_drain(60);
    chk("t4_ovr_set", overrun, 32'd1);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("t4_ovr_clr", overrun, 32'd0);
    strobe();
    repeat (3) step();
    overrun_clr = 1'b1;
    strobe();
    overrun_clr = 1'b0;
    chk("t4_set_wins", overrun, 32'd1);
    wait_drain(60);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("t4_cnt", frame_cnt, 32'd4);

    // T5: back-to-back frames
    set_pat(40, 5);
    strobe();
    repeat (23) step();
    chk("t5_ch23", out_chan, 32'd23);
    set_pat(32'h1ABCDE, -1);
    strobe();
    chk("t5_next_ch0", out_chan, 32'd0);
    chk("t5_next_data", out_data, 32'h1ABCDE);
    chk("t5_no_ovr", overrun, 32'd0);
    wait_drain(60);
    chk("t5_cnt", frame_cnt, 32'd6);

    // T6b: strobe with enable low in idle
    enable = 1'b0;
    strobe();
    step();
    chk("t6_dis_valid", out_valid, 32'd0);
    chk("t6_dis_ovr", overrun, 32'd0);
    enable = 1'b1;

    // T6c: frame counter wrap on the narrow instance
    repeat (9) begin
      set_pat($urandom_range(0, 1000), 11);
      strobe();
      wait_drain(60);
    end
    chk("t6_cnt15_w", frame_cnt_w, 32'd15);
    strobe();
    wait_drain(60);
    chk("t6_wrap_w", frame_cnt_w, 32'd0);
    chk("t6_cnt16", frame_cnt, 32'd16);
    step(); step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
